// File: rtl/regfile_wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter_pkg
// Shared RISC-V register-file definitions (riscv_def) used by the writeback
// arbiter and its scoreboard:
//   RS_WIDTH       - register index width
//   REG_DATA_WIDTH - register data width
//   REG_SIZE       - number of architectural registers
//   arb_state_t    - writeback arbiter FSM state encoding
// -----------------------------------------------------------------------------
package regfile_wb_arbiter_pkg;

    localparam int RS_WIDTH       = 5;
    localparam int REG_DATA_WIDTH = 32;
    localparam int REG_SIZE       = 1 << RS_WIDTH;

    typedef enum logic [0:0] {
        ST_NORMAL  = 1'b0,
        ST_FORCE_B = 1'b1
    } arb_state_t;

endpackage

// File: rtl/regfile_wb_arbiter_wb_scoreboard.sv
// -----------------------------------------------------------------------------
// wb_scoreboard
// Per-register pending-write scoreboard. A bit is set when a multi-cycle op
// targeting that register issues and cleared when its writeback retires.
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   i_issue_valid/i_issue_rd - multi-cycle op issued to rd
//   i_retire_valid/i_retire_rd - multi-cycle writeback accepted for rd
//   o_busy                  - one pending bit per register (bit 0 always 0)
// -----------------------------------------------------------------------------
module wb_scoreboard
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int RS_W = RS_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_issue_valid,
    input  logic [RS_W-1:0]      i_issue_rd,
    input  logic                 i_retire_valid,
    input  logic [RS_W-1:0]      i_retire_rd,
    output logic [2**RS_W-1:0]   o_busy
);

    localparam int unsigned NREG = 2**RS_W;

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_next;

    // Retire is applied first so a same-cycle issue to the same rd wins.
    always_comb begin
        w_busy_next = r_busy;
        for (int unsigned r = 1; r < NREG; r++) begin
            if (i_retire_valid && (i_retire_rd == RS_W'(r)))
                w_busy_next[r] = 1'b0;
            if (i_issue_valid && (i_issue_rd == RS_W'(r)))
                w_busy_next[r] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_busy <= '0;
        else
            r_busy <= w_busy_next;
    end

    assign o_busy = r_busy;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
// Arbitrates the single register-file write port between the pipeline (A,
// priority) and a multi-cycle unit (B). B is forced through after being
// refused STARVE_LIMIT consecutive cycles. Writes are registered one cycle
// after the handshake; writes to x0 are accepted and dropped.
// Ports:
//   clk, rst_n                    - clock, asynchronous active-low reset
//   a_valid/a_rd/a_data, a_ready  - pipeline writeback request
//   b_valid/b_rd/b_data, b_ready  - multi-cycle writeback request
//   issue_valid/issue_rd          - multi-cycle op issued (scoreboard set)
//   wr_en/wr_rd/wr_data           - register-file write port
//   busy                          - per-register pending-write scoreboard
// -----------------------------------------------------------------------------
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATA_W       = REG_DATA_WIDTH,
    parameter int RS_W         = RS_WIDTH,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 a_valid,
    input  logic [RS_W-1:0]      a_rd,
    input  logic [DATA_W-1:0]    a_data,
    output logic                 a_ready,
    input  logic                 b_valid,
    input  logic [RS_W-1:0]      b_rd,
    input  logic [DATA_W-1:0]    b_data,
    output logic                 b_ready,
    input  logic                 issue_valid,
    input  logic [RS_W-1:0]      issue_rd,
    output logic                 wr_en,
    output logic [RS_W-1:0]      wr_rd,
    output logic [DATA_W-1:0]    wr_data,
    output logic [2**RS_W-1:0]   busy
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    arb_state_t          r_state;
    arb_state_t          w_state_next;
    logic [CNT_W-1:0]    r_starve_cnt;
    logic [CNT_W-1:0]    w_starve_cnt_next;
    logic                w_a_grant;
    logic                w_b_grant;

    logic                r_wr_en;
    logic [RS_W-1:0]     r_wr_rd;
    logic [DATA_W-1:0]   r_wr_data;

    always_comb begin
        w_a_grant         = 1'b0;
        w_b_grant         = 1'b0;
        w_state_next      = r_state;
        w_starve_cnt_next = '0;

        unique case (r_state)
            ST_NORMAL: begin
                if (a_valid)      w_a_grant = 1'b1;
                else if (b_valid) w_b_grant = 1'b1;
            end
            ST_FORCE_B: begin
                if (b_valid)      w_b_grant = 1'b1;
                else if (a_valid) w_a_grant = 1'b1;
            end
            default: ;
        endcase

        // Readies are held low for as long as reset is asserted.
        if (!rst_n) begin
            w_a_grant = 1'b0;
            w_b_grant = 1'b0;
        end

        if (b_valid && !w_b_grant) begin
            if (r_starve_cnt < CNT_W'(STARVE_LIMIT))
                w_starve_cnt_next = r_starve_cnt + 1'b1;
            else
                w_starve_cnt_next = r_starve_cnt;
        end

        // Switching on the next count lets the forced B grant land on the
        // cycle right after the STARVE_LIMIT-th refusal.
        unique case (r_state)
            ST_NORMAL:  if (w_starve_cnt_next == CNT_W'(STARVE_LIMIT)) w_state_next = ST_FORCE_B;
            ST_FORCE_B: if (w_b_grant || !b_valid)                     w_state_next = ST_NORMAL;
            default:    w_state_next = ST_NORMAL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_NORMAL;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_state_next;
            r_starve_cnt <= w_starve_cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en   <= 1'b0;
            r_wr_rd   <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (w_a_grant) begin
                r_wr_en   <= (a_rd != '0);
                r_wr_rd   <= a_rd;
                r_wr_data <= a_data;
            end else if (w_b_grant) begin
                r_wr_en   <= (b_rd != '0);
                r_wr_rd   <= b_rd;
                r_wr_data <= b_data;
            end
        end
    end

    wb_scoreboard #(
        .RS_W (RS_W)
    ) u_scoreboard (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_issue_valid  (issue_valid),
        .i_issue_rd     (issue_rd),
        .i_retire_valid (w_b_grant),
        .i_retire_rd    (b_rd),
        .o_busy         (busy)
    );

    assign a_ready = w_a_grant;
    assign b_ready = w_b_grant;
    assign wr_en   = r_wr_en;
    assign wr_rd   = r_wr_rd;
    assign wr_data = r_wr_data;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int SL = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_valid, b_valid, issue_valid;
    logic [RW-1:0] a_rd, b_rd, issue_rd;
    logic [DW-1:0] a_data, b_data;
    logic          a_ready, b_ready;
    logic          wr_en;
    logic [RW-1:0] wr_rd;
    logic [DW-1:0] wr_data;
    logic [31:0]   busy;

    int tot = 0;
    int bad = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .DATA_W       (DW),
        .RS_W         (RW),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a_valid     (a_valid),
        .a_rd        (a_rd),
        .a_data      (a_data),
        .a_ready     (a_ready),
        .b_valid     (b_valid),
        .b_rd        (b_rd),
        .b_data      (b_data),
        .b_ready     (b_ready),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .wr_en       (wr_en),
        .wr_rd       (wr_rd),
        .wr_data     (wr_data),
        .busy        (busy)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        a_valid = 1'b1; a_rd = 5'd5; a_data = 32'h1;
        b_valid = 1'b1; b_rd = 5'd6; b_data = 32'h2;
        issue_valid = 1'b0; issue_rd = '0;
        #7;
        tot++; if (a_ready !== 1'b0) begin bad++; $display("FAIL reset_a_ready: got %b want 0", a_ready); end
        tot++; if (b_ready !== 1'b0) begin bad++; $display("FAIL reset_b_ready: got %b want 0", b_ready); end
        tot++; if (wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
        tot++; if (wr_rd !== 5'd0) begin bad++; $display("FAIL reset_wr_rd: got %h want 0", wr_rd); end
        tot++; if (wr_data !== 32'h0) begin bad++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
        tot++; if (busy !== 32'h0) begin bad++; $display("FAIL reset_busy: got %h want 0", busy); end
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_a_only();
        @(negedge clk);
        a_valid = 1'b1; a_rd = 5'd5; a_data = 32'h1234; b_valid = 1'b0;
        #1;
        tot++; if (a_ready !== 1'b1) begin bad++; $display("FAIL aonly_a_ready: got %b want 1", a_ready); end
        tot++; if (b_ready !== 1'b0) begin bad++; $display("FAIL aonly_b_ready: got %b want 0", b_ready); end
        @(posedge clk); #1;
        a_valid = 1'b0;
        tot++; if (wr_en !== 1'b1) begin bad++; $display("FAIL aonly_wr_en: got %b want 1", wr_en); end
        tot++; if (wr_rd !== 5'd5) begin bad++; $display("FAIL aonly_wr_rd: got %0d want 5", wr_rd); end
        tot++; if (wr_data !== 32'h1234) begin bad++; $display("FAIL aonly_wr_data: got %h want 1234", wr_data); end
        @(posedge clk); #1;
        tot++; if (wr_en !== 1'b0) begin bad++; $display("FAIL aonly_idle_wr_en: got %b want 0", wr_en); end
    endtask

    task automatic test_contention();
        logic          exp_a;
        logic [RW-1:0] exp_rd;
        logic [DW-1:0] exp_data;
        @(negedge clk);
        a_valid = 1'b1; a_rd = 5'd1; a_data = 32'hAAAA_0001;
        b_valid = 1'b1; b_rd = 5'd9; b_data = 32'hBBBB_0009;
        for (int c = 1; c <= 6; c++) begin
            if (c == 6) b_valid = 1'b0;
            #1;
            exp_a    = (c != 5);
            exp_rd   = exp_a ? 5'd1 : 5'd9;
            exp_data = exp_a ? 32'hAAAA_0001 : 32'hBBBB_0009;
            tot++; if (a_ready !== exp_a) begin bad++; $display("FAIL contention_a_ready c%0d: got %b want %b", c, a_ready, exp_a); end
            tot++; if (b_ready !== !exp_a) begin bad++; $display("FAIL contention_b_ready c%0d: got %b want %b", c, b_ready, !exp_a); end
            @(posedge clk); #1;
            tot++; if (wr_en !== 1'b1 || wr_rd !== exp_rd || wr_data !== exp_data) begin
                bad++; $display("FAIL contention_write c%0d: got en=%b rd=%0d data=%h want en=1 rd=%0d data=%h", c, wr_en, wr_rd, wr_data, exp_rd, exp_data);
            end
            @(negedge clk);
        end
        a_valid = 1'b0;
    endtask

    task automatic test_x0_drop();
        @(negedge clk);
        issue_valid = 1'b1; issue_rd = 5'd3;
        @(negedge clk);
        issue_valid = 1'b0;
        #1;
        tot++; if (busy !== 32'h0000_0008) begin bad++; $display("FAIL x0_pre_busy: got %h want 00000008", busy); end
        b_valid = 1'b1; b_rd = 5'd0; b_data = 32'hFFFF_FFFF;
        #1;
        tot++; if (b_ready !== 1'b1) begin bad++; $display("FAIL x0_b_ready: got %b want 1", b_ready); end
        tot++; if (a_ready !== 1'b0) begin bad++; $display("FAIL x0_a_ready: got %b want 0", a_ready); end
        @(posedge clk); #1;
        b_valid = 1'b0;
        tot++; if (wr_en !== 1'b0) begin bad++; $display("FAIL x0_wr_en: got %b want 0", wr_en); end
        tot++; if (busy !== 32'h0000_0008) begin bad++; $display("FAIL x0_busy: got %h want 00000008", busy); end
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        issue_valid = 1'b1; issue_rd = 5'd7;
        @(posedge clk); #1;
        issue_valid = 1'b0;
        tot++; if (busy !== 32'h0000_0088) begin bad++; $display("FAIL sb_issue: got %h want 00000088", busy); end
        @(negedge clk);
        b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h77;
        #1;
        tot++; if (b_ready !== 1'b1) begin bad++; $display("FAIL sb_retire_ready: got %b want 1", b_ready); end
        @(posedge clk); #1;
        b_valid = 1'b0;
        tot++; if (busy !== 32'h0000_0008) begin bad++; $display("FAIL sb_retire: got %h want 00000008", busy); end
        tot++; if (wr_en !== 1'b1 || wr_rd !== 5'd7 || wr_data !== 32'h77) begin
            bad++; $display("FAIL sb_retire_write: got en=%b rd=%0d data=%h want en=1 rd=7 data=77", wr_en, wr_rd, wr_data);
        end
        @(negedge clk);
        issue_valid = 1'b1; issue_rd = 5'd7;
        b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h70;
        #1;
        tot++; if (b_ready !== 1'b1) begin bad++; $display("FAIL sb_same_ready: got %b want 1", b_ready); end
        @(posedge clk); #1;
        issue_valid = 1'b0; b_valid = 1'b0;
        tot++; if (busy !== 32'h0000_0088) begin bad++; $display("FAIL sb_same_cycle: got %h want 00000088", busy); end
        @(negedge clk);
        issue_valid = 1'b1; issue_rd = 5'd0;
        a_valid = 1'b1; a_rd = 5'd7; a_data = 32'hA7;
        @(posedge clk); #1;
        issue_valid = 1'b0; a_valid = 1'b0;
        tot++; if (busy !== 32'h0000_0088) begin bad++; $display("FAIL sb_x0_and_a: got %h want 00000088", busy); end
        tot++; if (wr_en !== 1'b1 || wr_rd !== 5'd7 || wr_data !== 32'hA7) begin
            bad++; $display("FAIL sb_a_write: got en=%b rd=%0d data=%h want en=1 rd=7 data=a7", wr_en, wr_rd, wr_data);
        end
    endtask

    task automatic test_async_reset();
        logic exp_a;
        // Reset in the cycle after a B grant.
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h55;
        @(posedge clk); #1;
        b_valid = 1'b0;
        tot++; if (wr_en !== 1'b1) begin bad++; $display("FAIL areset_pre_wr_en: got %b want 1", wr_en); end
        #1;
        a_valid = 1'b1; b_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        tot++; if (wr_en !== 1'b0) begin bad++; $display("FAIL areset_wr_en: got %b want 0", wr_en); end
        tot++; if (wr_rd !== 5'd0 || wr_data !== 32'h0) begin bad++; $display("FAIL areset_wr_port: got rd=%0d data=%h want rd=0 data=0", wr_rd, wr_data); end
        tot++; if (busy !== 32'h0) begin bad++; $display("FAIL areset_busy: got %h want 0", busy); end
        tot++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin bad++; $display("FAIL areset_ready: got a=%b b=%b want a=0 b=0", a_ready, b_ready); end
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            tot++; if (wr_en !== 1'b0) begin bad++; $display("FAIL areset_no_write: got %b want 0", wr_en); end
        end
        // Build up starvation, reset mid-way: the full count must restart.
        @(negedge clk);
        a_valid = 1'b1; a_rd = 5'd2; a_data = 32'h22;
        b_valid = 1'b1; b_rd = 5'd4; b_data = 32'h44;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            #1;
            exp_a = (c != 5);
            tot++; if (a_ready !== exp_a || b_ready !== !exp_a) begin
                bad++; $display("FAIL areset_cnt c%0d: got a=%b b=%b want a=%b b=%b", c, a_ready, b_ready, exp_a, !exp_a);
            end
            @(negedge clk);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic          acc_a, acc_b, exp_en, mforce, ga, gb;
        logic [RW-1:0] exp_rd;
        logic [DW-1:0] exp_data;
        int            mcnt;
        acc_a = 1'b0; acc_b = 1'b0; exp_en = 1'b0; exp_rd = '0; exp_data = '0;
        mforce = 1'b0; mcnt = 0;
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (cyc > 0) begin
                tot++; if (wr_en !== exp_en || (exp_en && (wr_rd !== exp_rd || wr_data !== exp_data))) begin
                    bad++; $display("FAIL rnd_write cyc%0d: got en=%b rd=%0d data=%h want en=%b rd=%0d data=%h", cyc, wr_en, wr_rd, wr_data, exp_en, exp_rd, exp_data);
                end
            end
            if (!a_valid || acc_a) begin
                a_valid = ($urandom_range(0, 3) != 0);
                a_rd    = RW'($urandom_range(0, 31));
                a_data  = $urandom;
            end
            if (!b_valid || acc_b) begin
                b_valid = ($urandom_range(0, 1) != 0);
                b_rd    = RW'($urandom_range(0, 31));
                b_data  = $urandom;
            end
            #3;
            if (!mforce) begin ga = a_valid; gb = !a_valid && b_valid; end
            else         begin gb = b_valid; ga = !b_valid && a_valid; end
            tot++; if (a_ready && b_ready) begin bad++; $display("FAIL rnd_both_ready cyc%0d: got a=1 b=1 want at most one", cyc); end
            tot++; if (a_ready !== ga || b_ready !== gb) begin
                bad++; $display("FAIL rnd_grant cyc%0d: got a=%b b=%b want a=%b b=%b", cyc, a_ready, b_ready, ga, gb);
            end
            if (b_valid && !gb) mcnt = (mcnt < SL) ? mcnt + 1 : mcnt;
            else                mcnt = 0;
            if (!mforce && mcnt == SL)          mforce = 1'b1;
            else if (mforce && (gb || !b_valid)) mforce = 1'b0;
            acc_a = a_valid && a_ready;
            acc_b = b_valid && b_ready;
            exp_en = 1'b0;
            if (ga)      begin exp_en = (a_rd != '0); exp_rd = a_rd; exp_data = a_data; end
            else if (gb) begin exp_en = (b_rd != '0); exp_rd = b_rd; exp_data = b_data; end
            @(posedge clk); #1;
        end
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_a_only();
        test_contention();
        test_x0_drop();
        test_scoreboard();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
